// File: rtl/team_12_wbm_pkg.sv
// ============================================================================
// team_12_wbm_pkg : shared types and constants for the Wishbone master
// Revision: 1.0
// ============================================================================
`default_nettype none

package team_12_wbm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wbm_state_e;

  // 69-bit request word carried through the queue
  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wbm_req_t;

  localparam logic [31:0] RD_ERR_DATA = 32'h0;

endpackage

`default_nettype wire

// File: rtl/team_12_wb_master_if.sv
// ============================================================================
// team_12_wb_master_if : request/response channels plus Wishbone B4 bus
// Revision: 1.0
// ============================================================================
`default_nettype none

interface team_12_wb_master_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_adr;
  logic [31:0] req_dat;
  logic [3:0]  req_sel;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_O;
  logic        WE_O;
  logic        STB_O;
  logic        CYC_O;
  logic [31:0] DAT_I;
  logic        ACK_I;

  modport master (
    input  req_valid, req_we, req_adr, req_dat, req_sel,
    output req_ready,
    output rsp_valid, rsp_dat, rsp_err,
    input  rsp_ready,
    output ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
    input  DAT_I, ACK_I
  );

  modport slave (
    output req_valid, req_we, req_adr, req_dat, req_sel,
    input  req_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    output rsp_ready,
    input  ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
    output DAT_I, ACK_I
  );

endinterface

`default_nettype wire

// File: rtl/team_12_wbm_req_fifo.sv
// ============================================================================
// team_12_wbm_req_fifo : 2-entry synchronous request queue
// Revision: 1.0
// ============================================================================
`default_nettype none

module team_12_wbm_req_fifo
  import team_12_wbm_pkg::*;
(
  input  logic       clk_i,
  input  logic       nrst,
  input  logic       i_push,
  input  wbm_req_t   i_din,
  input  logic       i_pop,
  output wbm_req_t   o_dout,
  output logic       o_full,
  output logic       o_empty,
  output logic [1:0] o_count
);

  wbm_req_t   r_mem [0:1];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  // Push gated on count alone: a full queue refuses even if it pops this edge
  assign w_push = i_push && (r_count != 2'd2);
  assign w_pop  = i_pop  && (r_count != 2'd0);

  always_ff @(posedge clk_i) begin
    if (!nrst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/team_12_wb_master.sv
// ============================================================================
// team_12_wb_master : queued single-transfer Wishbone B4 master with timeout
// Revision: 1.0
// ============================================================================
`default_nettype none

module team_12_wb_master
  import team_12_wbm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                nrst,
  team_12_wb_master_if.master bus,
  output logic                busy
);

  localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  wbm_state_e r_state;
  wbm_state_e w_state_nxt;

  wbm_req_t   w_push_req;
  wbm_req_t   w_head;
  logic       w_full;
  logic       w_empty;
  logic [1:0] w_count;

  logic       w_pop;
  logic       w_ack_hit;
  logic       w_tmo_hit;
  logic       w_rsp_take;
  logic       w_tmo_expire;

  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_we;
  logic        r_stb;
  logic        r_cyc;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_dat;
  logic        r_rsp_err;

  assign w_push_req.we  = bus.req_we;
  assign w_push_req.sel = bus.req_sel;
  assign w_push_req.adr = bus.req_adr;
  assign w_push_req.dat = bus.req_dat;

  team_12_wbm_req_fifo u_req_fifo (
    .clk_i   (clk_i),
    .nrst    (nrst),
    .i_push  (bus.req_valid),
    .i_din   (w_push_req),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_tmo
      localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
      logic [c_cnt_w-1:0] r_tmo_cnt;

      always_ff @(posedge clk_i) begin
        if (!nrst) begin
          r_tmo_cnt <= '0;
        end else if (w_pop) begin
          r_tmo_cnt <= '0;
        end else if (r_state == ST_BUS && !bus.ACK_I && !w_tmo_expire) begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
      end

      assign w_tmo_expire = (r_tmo_cnt == c_tmo_last);
    end else begin : g_no_tmo
      assign w_tmo_expire = 1'b0;
    end
  endgenerate

  // ACK is tested before the timeout so a coincident ACK completes normally
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_ack_hit   = 1'b0;
    w_tmo_hit   = 1'b0;
    w_rsp_take  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_BUS;
        end
      end
      ST_BUS: begin
        if (bus.ACK_I) begin
          w_ack_hit   = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_tmo_expire) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_take  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst) begin
      r_adr       <= 32'h0;
      r_dat       <= 32'h0;
      r_sel       <= 4'h0;
      r_we        <= 1'b0;
      r_stb       <= 1'b0;
      r_cyc       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_adr <= w_head.adr;
        r_dat <= w_head.dat;
        r_sel <= w_head.sel;
        r_we  <= w_head.we;
        r_stb <= 1'b1;
        r_cyc <= 1'b1;
      end
      if (w_ack_hit) begin
        r_cyc       <= 1'b0;
        r_stb       <= 1'b0;
        r_we        <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b0;
        r_rsp_dat   <= r_we ? RD_ERR_DATA : bus.DAT_I;
      end
      if (w_tmo_hit) begin
        r_cyc       <= 1'b0;
        r_stb       <= 1'b0;
        r_we        <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_rsp_dat   <= RD_ERR_DATA;
      end
      if (w_rsp_take) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready = !w_full;
  assign bus.ADR_O     = r_adr;
  assign bus.DAT_O     = r_dat;
  assign bus.SEL_O     = r_sel;
  assign bus.WE_O      = r_we;
  assign bus.STB_O     = r_stb;
  assign bus.CYC_O     = r_cyc;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_dat   = r_rsp_dat;
  assign bus.rsp_err   = r_rsp_err;
  assign busy          = (w_count != 2'd0) || (r_state != ST_IDLE);

endmodule

`default_nettype wire
